// File: rtl/stream_mux_rr.sv
// Registered N-to-1 stream multiplexer with valid/ready handshake.
// Channels are granted either by an external select or by round-robin
// starting at the channel after the last one granted; the single output
// register supports full-throughput pass-through and downstream backpressure.
module stream_mux_rr #(
  parameter int unsigned DATA_WIDTH = 35,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             select,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]             out_ch,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned     SEL_N   = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SEL_W-1:0]        ch_q, ch_d;
  logic [SEL_W-1:0]        rr_ptr_q, rr_ptr_d;

  logic [SEL_N-1:0]        valid_pad;
  logic [DATA_WIDTH-1:0]   ch_data [SEL_N];
  logic                    sel_in_range;
  logic [SEL_W-1:0]        rr_grant;
  logic                    rr_found;
  int unsigned             rr_idx;
  logic [SEL_W-1:0]        grant;
  logic                    grant_valid;
  logic                    slot_free;
  logic                    accept;

  // Pad valids and channel words to the full select range so any index is safe
  assign valid_pad = SEL_N'(in_valid);

  for (genvar g = 0; g < SEL_N; g++) begin : g_unpack
    if (g < NUM_CH) begin : g_live
      assign ch_data[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign ch_data[g] = '0;
    end
  end

  assign sel_in_range = (32'(select) < NUM_CH);

  // Round-robin search: first valid channel at or after rr_ptr, wrapping
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      rr_idx = (32'(rr_ptr_q) + k) % NUM_CH;
      if (!rr_found && valid_pad[SEL_W'(rr_idx)]) begin
        rr_found = 1'b1;
        rr_grant = SEL_W'(rr_idx);
      end
    end
  end

  // Grant source selection; out-of-range fixed select grants nothing
  always_comb begin
    grant       = select;
    grant_valid = sel_in_range && valid_pad[select];
    if (mode) begin
      grant       = rr_grant;
      grant_valid = rr_found;
    end
  end

  assign slot_free = (state_q == ST_EMPTY) || out_ready;
  assign accept    = enable && slot_free && grant_valid && !reset;

  // One-hot (or zero) accept strobe back to the granted channel
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      in_ready[i] = accept && (grant == SEL_W'(i));
    end
  end

  // Output register state and datapath next-state
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    ch_d     = ch_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      data_d   = ch_data[grant];
      ch_d     = grant;
      rr_ptr_d = (grant == LAST_CH) ? '0 : grant + SEL_W'(1);
    end
  end

  // State and output registers; reset discards any held word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      ch_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule
